// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage with the IF/ID pipeline register. The stage keeps the
// PC and issues one outstanding request at a time to instruction memory. It
// captures each returned instruction together with its PC and PC+4, and
// presents the opcode field to the control unit.
// A stall from the hazard unit that arrives in the same cycle as an accepted
// fetch parks that instruction in a one-entry hold buffer. No request is issued
// while the buffer is occupied. A redirect (taken branch, jal, jalr) reloads the
// PC and flushes IF/ID.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_req/addr     : fetch request and address (address equals the PC)
//   imem_ready/rdata  : memory accept and same-cycle instruction data
//   stall             : hold IF/ID and the PC
//   redirect/_pc      : redirect request and target (low two bits ignored)
//   ifid_valid/inst   : IF/ID valid flag and instruction (NOP when not valid)
//   ifid_pc/pc4       : PC of ifid_inst and that PC plus four
//   opcode            : ifid_inst[6:0]
// -----------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
    parameter logic [31:0]      NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ifid_valid,
    output logic [31:0]     ifid_inst,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4,
    output logic [6:0]      opcode
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] ZERO_PC    = {XLEN{1'b0}};

    // PC increment, wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

    state_t          state_q,      state_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic [31:0]     buf_inst_q,   buf_inst_d;
    logic [XLEN-1:0] buf_pc_q,     buf_pc_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [31:0]     ifid_inst_q,  ifid_inst_d;
    logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;
    logic [XLEN-1:0] ifid_pc4_q,   ifid_pc4_d;
    logic            accept_s;

    // A transaction completes only while requesting and memory is ready.
    assign accept_s = (state_q == S_REQ) && imem_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. Redirect always returns to requesting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (!redirect && accept_s && stall) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // FSM outputs: request only in S_REQ and never while reset is asserted.
    always_comb begin
        imem_req = 1'b0;
        if (rst_n && (state_q == S_REQ)) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    // Datapath next-state: PC, hold buffer and IF/ID register.
    always_comb begin
        pc_d         = pc_q;
        buf_inst_d   = buf_inst_q;
        buf_pc_d     = buf_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        if (redirect) begin
            // Flush wins over stall. Any accepted data or buffered entry is dropped.
            pc_d         = redirect_pc & ALIGN_MASK;
            ifid_valid_d = 1'b0;
            ifid_inst_d  = NOP_INST;
        end else if (state_q == S_REQ) begin
            if (accept_s && !stall) begin
                ifid_valid_d = 1'b1;
                ifid_inst_d  = imem_rdata;
                ifid_pc_d    = pc_q;
                ifid_pc4_d   = pc_inc(pc_q);
                pc_d         = pc_inc(pc_q);
            end else if (accept_s) begin
                // IF/ID is frozen, so park the instruction and advance the PC.
                buf_inst_d = imem_rdata;
                buf_pc_d   = pc_q;
                pc_d       = pc_inc(pc_q);
            end else if (!stall) begin
                ifid_valid_d = 1'b0;
                ifid_inst_d  = NOP_INST;
            end else begin
                ifid_valid_d = ifid_valid_q;
            end
        end else begin
            if (!stall) begin
                ifid_valid_d = 1'b1;
                ifid_inst_d  = buf_inst_q;
                ifid_pc_d    = buf_pc_q;
                ifid_pc4_d   = pc_inc(buf_pc_q);
            end else begin
                ifid_valid_d = ifid_valid_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            buf_inst_q   <= NOP_INST;
            buf_pc_q     <= ZERO_PC;
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= NOP_INST;
            ifid_pc_q    <= ZERO_PC;
            ifid_pc4_q   <= ZERO_PC;
        end else begin
            pc_q         <= pc_d;
            buf_inst_q   <= buf_inst_d;
            buf_pc_q     <= buf_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_inst  = ifid_inst_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign opcode     = ifid_inst_q[6:0];

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. Directed scenarios are followed by
// randomized ready/stall/redirect traffic. A behavioural reference model
// predicts the fetch address and the IF/ID contents for every cycle.
// A second instance built with RESET_PC = 32'hFFFF_FFFC checks PC wrap-around.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        ifid_valid;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [6:0]  opcode;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ready = 1'b1;
    logic [31:0] w_rdata;
    logic        w_stall = 1'b0;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'd0;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic [6:0]  w_opcode;

    int n_checks = 0;
    int n_errors = 0;

    // Address-tagged instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000 ^ {25'd0, a[8:2]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign w_rdata    = mem_word(w_addr);

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_inst(ifid_inst),
        .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .opcode(opcode)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(w_ready), .imem_rdata(w_rdata),
        .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .ifid_valid(w_valid), .ifid_inst(w_inst),
        .ifid_pc(w_pc), .ifid_pc4(w_pc4), .opcode(w_opcode)
    );

    // Reference model state: next fetch PC, the parked instruction (if any) and IF/ID.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic [31:0] m_pc;
    ent_t        m_buf[$];
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_buf.delete();
        m_valid = 1'b0;
        m_inst  = NOP;
        m_ipc   = 32'd0;
        m_ipc4  = 32'd0;
    endtask

    // Advance the model by one clock, given the inputs held during that cycle.
    task automatic model_step(input logic rdy, input logic st, input logic rd, input logic [31:0] rpc);
        ent_t e;
        if (rd) begin
            m_pc    = rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_inst  = NOP;
            m_buf.delete();
        end else if (m_buf.size() != 0) begin
            if (!st) begin
                e       = m_buf.pop_front();
                m_valid = 1'b1;
                m_inst  = e.inst;
                m_ipc   = e.pc;
                m_ipc4  = e.pc + 32'd4;
            end
        end else if (rdy) begin
            if (st) begin
                e.inst = mem_word(m_pc);
                e.pc   = m_pc;
                m_buf.push_back(e);
            end else begin
                m_valid = 1'b1;
                m_inst  = mem_word(m_pc);
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 32'd4;
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_valid = 1'b0;
            m_inst  = NOP;
        end
    endtask

    // Compare the DUT with the model, drive the inputs for this cycle and advance the model.
    task automatic step(input logic rdy, input logic st, input logic rd, input logic [31:0] rpc);
        chk("req",    {31'd0, imem_req},   {31'd0, (m_buf.size() == 0)});
        chk("addr",   imem_addr,           m_pc);
        chk("valid",  {31'd0, ifid_valid}, {31'd0, m_valid});
        chk("inst",   ifid_inst,           m_inst);
        chk("opcode", {25'd0, opcode},     {25'd0, m_inst[6:0]});
        if (m_valid) begin
            chk("pc",  ifid_pc,  m_ipc);
            chk("pc4", ifid_pc4, m_ipc4);
        end
        imem_ready  = rdy;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        model_step(rdy, st, rd, rpc);
    endtask

    task automatic cycle(input logic rdy, input logic st, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        #1;
        step(rdy, st, rd, rpc);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},   32'd0);
        chk({tag, "_addr"},  imem_addr,           32'h0000_0000);
        chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
        chk({tag, "_inst"},  ifid_inst,           NOP);
        chk({tag, "_pc"},    ifid_pc,             32'd0);
        chk({tag, "_pc4"},   ifid_pc4,            32'd0);
        chk({tag, "_wreq"},  {31'd0, w_req},      32'd0);
        chk({tag, "_waddr"}, w_addr,              32'hFFFF_FFFC);
    endtask

    initial begin
        logic st_r;
        model_reset();
        @(negedge clk);
        #1;
        check_reset_values("rst");

        // Release reset; the first request goes out at RESET_PC.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step(1'b1, 1'b0, 1'b0, 32'd0);          // fetch 0

        // The wrap instance fetched 0xFFFF_FFFC; its PC+4 and next fetch wrap to 0.
        @(negedge clk);
        #1;
        chk("wrap_valid", {31'd0, w_valid}, 32'd1);
        chk("wrap_pc",    w_pc,             32'hFFFF_FFFC);
        chk("wrap_pc4",   w_pc4,            32'd0);
        chk("wrap_addr",  w_addr,           32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);          // fetch 4

        // Memory not ready for three cycles at pc=8.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);         // fetch 8
        cycle(1'b1, 1'b1, 1'b0, 32'd0);         // fetch 12 under stall -> hold buffer
        cycle(1'b1, 1'b1, 1'b0, 32'd0);         // held
        cycle(1'b1, 1'b0, 1'b0, 32'd0);         // release: 12 enters IF/ID
        cycle(1'b1, 1'b0, 1'b0, 32'd0);         // fetch 16
        cycle(1'b1, 1'b1, 1'b0, 32'd0);         // fetch 20 under stall
        cycle(1'b1, 1'b1, 1'b0, 32'd0);         // held
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103); // redirect while held

        @(negedge clk);
        #1;
        chk("redir_addr",  imem_addr,           32'h0000_0100);
        chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
        chk("redir_req",   {31'd0, imem_req},   32'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0);

        // Randomized traffic with an asynchronous reset in the middle.
        st_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_values("arst");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                step(1'b1, 1'b0, 1'b0, 32'd0);
                @(negedge clk);
                #1;
                chk("arst_restart_pc", ifid_pc, 32'h0000_0000);
                step(1'b1, 1'b0, 1'b0, 32'd0);
            end else begin
                if ($urandom_range(0, 3) == 0) st_r = ~st_r;
                cycle(($urandom_range(0, 3) != 0), st_r,
                      ($urandom_range(0, 15) == 0), $urandom);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
